// File: rtl/aes_pkg.sv
// Shared types and default round counts for the AES round sequencer.
package aes_pkg;

    typedef enum logic [1:0] {
        KS_128  = 2'b00,
        KS_192  = 2'b01,
        KS_256  = 2'b10,
        KS_RSVD = 2'b11
    } key_size_e;

    localparam int NR_128_DEF = 10;
    localparam int NR_192_DEF = 12;
    localparam int NR_256_DEF = 14;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Control/status bundle between the cipher control FSM (master) and the round sequencer (slave).
// AES_RSEQ_DECRYPT_EN adds the decrypt request and the reversed key index.
interface aes_round_sequencer_if #(
    parameter int RW = 4
);
    logic          start;
    logic [1:0]    key_size;
    logic          advance;
    logic          abort;
`ifdef AES_RSEQ_DECRYPT_EN
    logic          decrypt;
    logic [RW-1:0] key_idx;
`endif
    logic [RW-1:0] round;
    logic [RW-1:0] nr;
    logic          busy;
    logic          is_first;
    logic          is_final;
    logic          done;
    logic          cfg_err;

    modport master (
        output start, key_size, advance, abort,
`ifdef AES_RSEQ_DECRYPT_EN
        output decrypt,
        input  key_idx,
`endif
        input  round, nr, busy, is_first, is_final, done, cfg_err
    );

    modport slave (
        input  start, key_size, advance, abort,
`ifdef AES_RSEQ_DECRYPT_EN
        input  decrypt,
        output key_idx,
`endif
        output round, nr, busy, is_first, is_final, done, cfg_err
    );

endinterface

// File: rtl/aes_round_sequencer.sv
// Paces AES rounds 0..Nr for 128/192/256-bit keys, one round per accepted advance.
// Optional feature macro: AES_RSEQ_DECRYPT_EN (decrypt input, reversed key_idx output).
//
// state  | meaning
// S_IDLE | waiting for start; advance/abort ignored
// S_RUN  | round in progress; round steps on advance, abort wins over advance
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR_128 = NR_128_DEF,
    parameter int NR_192 = NR_192_DEF,
    parameter int NR_256 = NR_256_DEF,
    parameter int RW     = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    aes_round_sequencer_if.slave  bus
);

    state_e        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [RW-1:0] nr_q, nr_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;
    logic [RW-1:0] nr_sel;
    key_size_e     ks;

    assign ks = key_size_e'(bus.key_size);

    always_comb begin
        nr_sel = RW'(NR_128);
        case (ks)
            KS_192:  nr_sel = RW'(NR_192);
            KS_256:  nr_sel = RW'(NR_256);
            default: nr_sel = RW'(NR_128);
        endcase
    end

`ifdef AES_RSEQ_DECRYPT_EN
    logic decrypt_q, decrypt_d;
`endif

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        nr_d      = nr_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
`ifdef AES_RSEQ_DECRYPT_EN
        decrypt_d = decrypt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (ks == KS_RSVD) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        nr_d    = nr_sel;
                        round_d = '0;
                        state_d = S_RUN;
`ifdef AES_RSEQ_DECRYPT_EN
                        decrypt_d = bus.decrypt;
`endif
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    round_d = '0;
                end else if (bus.advance) begin
                    if (round_q == nr_q) begin
                        state_d = S_IDLE;
                        round_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            round_q   <= '0;
            nr_q      <= RW'(NR_128);
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef AES_RSEQ_DECRYPT_EN
            decrypt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            nr_q      <= nr_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
`ifdef AES_RSEQ_DECRYPT_EN
            decrypt_q <= decrypt_d;
`endif
        end
    end

    // Status flags decode only from registered state; no input-to-output paths.
    assign bus.round    = round_q;
    assign bus.nr       = nr_q;
    assign bus.busy     = (state_q == S_RUN);
    assign bus.is_first = (state_q == S_RUN) && (round_q == '0);
    assign bus.is_final = (state_q == S_RUN) && (round_q == nr_q);
    assign bus.done     = done_q;
    assign bus.cfg_err  = cfg_err_q;
`ifdef AES_RSEQ_DECRYPT_EN
    assign bus.key_idx  = decrypt_q ? (nr_q - round_q) : round_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking bench for aes_round_sequencer (default build; decrypt checks when AES_RSEQ_DECRYPT_EN is set).
module tb_aes_round_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    aes_round_sequencer_if #(.RW(4)) bus ();

    aes_round_sequencer #(
        .NR_128(10), .NR_192(12), .NR_256(14), .RW(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] ks);
        bus.start    = 1'b1;
        bus.key_size = ks;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        total++;
        if (bus.busy !== 1'b0 || bus.round !== 4'd0 || bus.nr !== 4'd10 ||
            bus.is_first !== 1'b0 || bus.is_final !== 1'b0 || bus.done !== 1'b0 ||
            bus.cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals busy=%b round=%0d nr=%0d first=%b final=%b done=%b cfg_err=%b want 0/0/10/0/0/0/0",
                     bus.busy, bus.round, bus.nr, bus.is_first, bus.is_final, bus.done, bus.cfg_err);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_aes128();
        do_start(2'b00);
        total++;
        if (bus.busy !== 1'b1 || bus.round !== 4'd0 || bus.is_first !== 1'b1 || bus.nr !== 4'd10) begin
            bad++;
            $display("FAIL a128_start busy=%b round=%0d first=%b nr=%0d want 1/0/1/10",
                     bus.busy, bus.round, bus.is_first, bus.nr);
        end
        bus.advance = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            total++;
            if (bus.round !== 4'(i) || bus.is_final !== (i == 10) || bus.done !== 1'b0 ||
                bus.is_first !== (i == 0) || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL a128_round i=%0d round=%0d final=%b first=%b done=%b busy=%b",
                         i, bus.round, bus.is_final, bus.is_first, bus.done, bus.busy);
            end
            step();
        end
        bus.advance = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.round !== 4'd0 || bus.is_final !== 1'b0) begin
            bad++;
            $display("FAIL a128_done done=%b busy=%b round=%0d final=%b want 1/0/0/0",
                     bus.done, bus.busy, bus.round, bus.is_final);
        end
        step();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL a128_pulse done=%b busy=%b want 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_gaps(input logic [1:0] ks, input int exp_nr);
        int  accepted;
        bit  finished;
        logic adv;
        accepted = 0;
        finished = 1'b0;
        do_start(ks);
        total++;
        if (bus.nr !== 4'(exp_nr) || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL gaps_nr nr=%0d busy=%b want %0d/1", bus.nr, bus.busy, exp_nr);
        end
        for (int c = 0; c < 300 && !finished; c++) begin
            adv = 1'($urandom_range(0, 1));
            bus.advance = adv;
            if (bus.busy === 1'b1 && bus.round > bus.nr) begin
                bad++;
                total++;
                $display("FAIL gaps_bound round=%0d nr=%0d", bus.round, bus.nr);
            end
            step();
            if (adv) accepted++;
            if (bus.done === 1'b1) finished = 1'b1;
        end
        bus.advance = 1'b0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL gaps_timeout nr=%0d no done within budget", exp_nr);
        end else if (accepted != exp_nr + 1) begin
            bad++;
            $display("FAIL gaps_count accepted=%0d want %0d", accepted, exp_nr + 1);
        end
        step();
    endtask

    task automatic test_rsvd(input int prev_nr);
        do_start(2'b11);
        total++;
        if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0 || bus.nr !== 4'(prev_nr)) begin
            bad++;
            $display("FAIL rsvd cfg_err=%b busy=%b nr=%0d want 1/0/%0d",
                     bus.cfg_err, bus.busy, bus.nr, prev_nr);
        end
        step();
        total++;
        if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rsvd_pulse cfg_err=%b busy=%b want 0/0", bus.cfg_err, bus.busy);
        end
    endtask

    task automatic test_abort();
        do_start(2'b00);
        bus.advance = 1'b1;
        step();
        step();
        bus.start    = 1'b1;
        bus.key_size = 2'b10;
        step();
        bus.start    = 1'b0;
        total++;
        if (bus.round !== 4'd3 || bus.nr !== 4'd10 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL midrun_start round=%0d nr=%0d busy=%b want 3/10/1", bus.round, bus.nr, bus.busy);
        end
        step();
        step();
        total++;
        if (bus.round !== 4'd5) begin
            bad++;
            $display("FAIL abort_pre round=%0d want 5", bus.round);
        end
        bus.abort = 1'b1;
        step();
        bus.abort   = 1'b0;
        bus.advance = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.round !== 4'd0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL abort busy=%b round=%0d done=%b want 0/0/0", bus.busy, bus.round, bus.done);
        end
        step();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_after done=%b busy=%b want 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        do_start(2'b01);
        bus.advance = 1'b1;
        for (int i = 0; i < 13; i++) step();
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done done=%b want 1", bus.done);
        end
        bus.start    = 1'b1;
        bus.key_size = 2'b00;
        step();
        bus.start   = 1'b0;
        bus.advance = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.round !== 4'd0 || bus.is_first !== 1'b1 ||
            bus.nr !== 4'd10 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_start busy=%b round=%0d first=%b nr=%0d done=%b want 1/0/1/10/0",
                     bus.busy, bus.round, bus.is_first, bus.nr, bus.done);
        end
    endtask

    task automatic test_async_reset();
        bus.advance = 1'b1;
        for (int i = 0; i < 7; i++) step();
        bus.advance = 1'b0;
        total++;
        if (bus.round !== 4'd7) begin
            bad++;
            $display("FAIL arst_pre round=%0d want 7", bus.round);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.round !== 4'd0 || bus.nr !== 4'd10 || bus.done !== 1'b0 ||
            bus.is_first !== 1'b0 || bus.is_final !== 1'b0 || bus.cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL arst busy=%b round=%0d nr=%0d done=%b first=%b final=%b cfg_err=%b",
                     bus.busy, bus.round, bus.nr, bus.done, bus.is_first, bus.is_final, bus.cfg_err);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef AES_RSEQ_DECRYPT_EN
    task automatic test_decrypt();
        bus.decrypt = 1'b1;
        do_start(2'b10);
        bus.decrypt = 1'b0;
        bus.advance = 1'b1;
        for (int i = 0; i <= 14; i++) begin
            total++;
            if (bus.key_idx !== 4'(14 - i) || bus.round !== 4'(i)) begin
                bad++;
                $display("FAIL decrypt i=%0d key_idx=%0d round=%0d want %0d/%0d",
                         i, bus.key_idx, bus.round, 14 - i, i);
            end
            step();
        end
        bus.advance = 1'b0;
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL decrypt_done done=%b want 1", bus.done);
        end
        step();
    endtask
`endif

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.key_size = 2'b00;
        bus.advance  = 1'b0;
        bus.abort    = 1'b0;
`ifdef AES_RSEQ_DECRYPT_EN
        bus.decrypt  = 1'b0;
`endif
        test_reset();
        test_aes128();
        test_gaps(2'b01, 12);
        test_gaps(2'b10, 14);
        test_rsvd(14);
        test_abort();
        test_back_to_back();
        test_async_reset();
`ifdef AES_RSEQ_DECRYPT_EN
        test_decrypt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
